// File: rtl/rca_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder.
// Holds the default geometry and the per-stage slice width computation.
package rca_pkg;

  localparam int RCA_WIDTH  = 16;
  localparam int RCA_STAGES = 4;

  function automatic int chunk_of(input int w, input int s);
    return w / s;
  endfunction

  function automatic bit cfg_ok(input int w, input int s);
    return (w >= 2) && (s >= 1) && ((w % s) == 0);
  endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational CHUNK-bit ripple-carry slice.
// A plain chain of full adders; one instance per pipeline stage.
module rca_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[CHUNK];

endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder: STAGES registered slices of CHUNK bits.
// Optional signed-overflow output enabled by macro RCA_PIPE_OVERFLOW_EN.
module rca_pipe
  import rca_pkg::*;
#(
  parameter int WIDTH  = RCA_WIDTH,
  parameter int STAGES = RCA_STAGES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef RCA_PIPE_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = chunk_of(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $fatal(1, "rca_pipe: WIDTH>=2, STAGES>=1, STAGES must divide WIDTH");
  end

  // Whole pipe moves together; it only stalls on a blocked result
  logic adv;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int ACC = (k + 1) * CHUNK;
    localparam int REM = WIDTH - ACC;

    logic [CHUNK-1:0] x;
    logic [CHUNK-1:0] y;
    logic [CHUNK-1:0] s;
    logic             ci;
    logic             co;
    logic             vld_in;
    logic [ACC-1:0]   acc_in;
    logic             vld_d, vld_q;
    logic             cy_d, cy_q;
    logic [ACC-1:0]   acc_d, acc_q;

    if (k == 0) begin : g_first
      assign x      = a[CHUNK-1:0];
      assign y      = b[CHUNK-1:0];
      assign ci     = cin;
      assign vld_in = in_valid;
      assign acc_in = s;
    end else begin : g_next
      assign x      = g_stg[k-1].g_fwd.ra_q[CHUNK-1:0];
      assign y      = g_stg[k-1].g_fwd.rb_q[CHUNK-1:0];
      assign ci     = g_stg[k-1].cy_q;
      assign vld_in = g_stg[k-1].vld_q;
      assign acc_in = {s, g_stg[k-1].acc_q};
    end

    rca_slice #(
      .CHUNK (CHUNK)
    ) u_slice (
      .x  (x),
      .y  (y),
      .ci (ci),
      .s  (s),
      .co (co)
    );

    // Capture this slice's result and carry on advance, else hold
    always_comb begin
      vld_d = vld_q;
      cy_d  = cy_q;
      acc_d = acc_q;
      if (adv) begin
        vld_d = vld_in;
        cy_d  = co;
        acc_d = acc_in;
      end
    end

    // Stage state register
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        vld_q <= 1'b0;
        cy_q  <= 1'b0;
        acc_q <= '0;
      end else begin
        vld_q <= vld_d;
        cy_q  <= cy_d;
        acc_q <= acc_d;
      end
    end

    if (k < LAST) begin : g_fwd
      logic [REM-1:0] ra_in, rb_in;
      logic [REM-1:0] ra_d, ra_q;
      logic [REM-1:0] rb_d, rb_q;

      if (k == 0) begin : g_src
        assign ra_in = a[WIDTH-1:CHUNK];
        assign rb_in = b[WIDTH-1:CHUNK];
      end else begin : g_src
        assign ra_in = g_stg[k-1].g_fwd.ra_q[REM+CHUNK-1:CHUNK];
        assign rb_in = g_stg[k-1].g_fwd.rb_q[REM+CHUNK-1:CHUNK];
      end

      // Carry the not-yet-added operand bits to later stages
      always_comb begin
        ra_d = ra_q;
        rb_d = rb_q;
        if (adv) begin
          ra_d = ra_in;
          rb_d = rb_in;
        end
      end

      // Remaining-operand register
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          ra_q <= '0;
          rb_q <= '0;
        end else begin
          ra_q <= ra_d;
          rb_q <= rb_d;
        end
      end
    end
  end

  assign out_valid = g_stg[LAST].vld_q;
  assign sum       = g_stg[LAST].acc_q;
  assign cout      = g_stg[LAST].cy_q;

`ifdef RCA_PIPE_OVERFLOW_EN
  logic ovf_d, ovf_q;

  // Signed overflow from the operand MSBs seen by the top slice
  always_comb begin
    ovf_d = ovf_q;
    if (adv) begin
      ovf_d = (g_stg[LAST].x[CHUNK-1] == g_stg[LAST].y[CHUNK-1]) &
              (g_stg[LAST].s[CHUNK-1] != g_stg[LAST].x[CHUNK-1]);
    end
  end

  // Overflow flag register, aligned with sum
  always_ff @(posedge clock or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule
